// File: rtl/io_out_buf_if.sv
// io_out_buf_if: peripheral-side handshake bundle of the output write buffer.
//
// Signals:
//   dev_valid  head entry available (driven by the buffer)
//   dev_addr   head entry output port address (driven by the buffer)
//   dev_data   head entry data (driven by the buffer)
//   dev_ready  peripheral accepts the head entry (driven by the peripheral)
//
// Handshake: an entry transfers at a rising clk edge where dev_valid and
// dev_ready are both 1. While dev_valid is 1 and dev_ready is 0 the
// buffer holds dev_addr/dev_data stable. dev_valid never depends
// combinationally on dev_ready; dev_ready may be asserted at any time,
// and it has no effect while dev_valid is 0.
//
// Modports: master = buffer side, slave = peripheral side.

interface io_out_buf_if #(
   parameter int NBADDR = 3,
   parameter int NUBITS = 32
);
   logic              dev_valid;
   logic [NBADDR-1:0] dev_addr;
   logic [NUBITS-1:0] dev_data;
   logic              dev_ready;

   modport master (
      output dev_valid,
      output dev_addr,
      output dev_data,
      input  dev_ready
   );

   modport slave (
      input  dev_valid,
      input  dev_addr,
      input  dev_data,
      output dev_ready
   );
endinterface

// File: rtl/io_out_buf.sv
// io_out_buf: output-port write buffer between the core's output interface
// and external peripherals. Every core output write is captured into a FIFO
// and drained in order through a valid/ready handshake, absorbing bursts
// of OUT instructions while peripherals are busy.
//
// Ports:
//   clk       clock
//   rst       reset, asynchronous, active-high
//   out_en    core output write strobe (one cycle per write)
//   addr_out  core output port address
//   data_in   core output data
//   dev       io_out_buf_if.master: dev_valid/dev_addr/dev_data out, dev_ready in
//   full      count == FDEPTH
//   empty     count == 0
//   count     number of stored entries
//   ovf       sticky overflow flag        (only with IO_OUT_OVF_EN)
//   ovf_clr   clears ovf                  (only with IO_OUT_OVF_EN)
//
// Optional feature macro: IO_OUT_OVF_EN adds the sticky overflow flag.
// Without it, writes arriving while full (and not popping) are dropped
// silently.

module io_out_buf #(
   parameter  int NUBITS = 32,
   parameter  int NUIOOU = 8,
   parameter  int FDEPTH = 8,
   localparam int NBADDR = $clog2(NUIOOU),
   localparam int NPTR   = $clog2(FDEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              out_en,
   input  logic [NBADDR-1:0] addr_out,
   input  logic [NUBITS-1:0] data_in,
   io_out_buf_if.master      dev,
   output logic              full,
   output logic              empty,
   output logic [NPTR:0]     count
`ifdef IO_OUT_OVF_EN
   ,
   output logic              ovf,
   input  logic              ovf_clr
`endif
);

   localparam logic [NPTR:0] FULL_CNT = (NPTR+1)'(FDEPTH);
   localparam int            EW       = NBADDR + NUBITS;

   logic [EW-1:0]   mem [FDEPTH];
   logic [NPTR-1:0] wp;
   logic [NPTR-1:0] rp;
   logic            push;
   logic            pop;
   logic [EW-1:0]   head;

   // Flags decode only from the count register, so dev_valid never has a
   // combinational path from out_en or dev_ready.
   assign full          = (count == FULL_CNT);
   assign empty         = (count == '0);
   assign dev.dev_valid = ~empty;

   // A pop at full frees a slot in the same edge, so a write is still
   // accepted then; only out_en & full & ~pop is dropped.
   assign pop  = dev.dev_valid & dev.dev_ready;
   assign push = out_en & (~full | pop);

   // First-word-fall-through: head entry is a combinational array read.
   assign head         = mem[rp];
   assign dev.dev_addr = head[NUBITS +: NBADDR];
   assign dev.dev_data = head[NUBITS-1:0];

   // Storage is deliberately not reset; entries are only observable once
   // count says they were written after reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wp] <= {addr_out, data_in};
      end
   end

   // Pointers are NPTR bits wide and wrap naturally since FDEPTH is 2**NPTR.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wp <= wp + 1'b1;
         end
         if (pop) begin
            rp <= rp + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef IO_OUT_OVF_EN
   // Sticky: setting has priority over clearing in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (out_en & full & ~pop) begin
         ovf <= 1'b1;
      end else if (ovf_clr) begin
         ovf <= 1'b0;
      end
   end
`endif

endmodule
